// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer
// ----------------------------------------------------------------------------
// Upstream control stage for the small gate-level ALU. A command (A, B, op)
// is accepted over a valid/ready handshake and its operands are driven onto
// the ALU from registers, so they stay stable while the ALU's gate-delay paths
// settle. After a programmable number of clocks the ALU outputs are captured
// into an output buffer with its own valid/ready handshake. The last captured
// result is kept in an accumulator so commands can chain on it.
//
// Parameters
//   WIDTH          operand/result width (must match the ALU)
//   SETTLE_CYCLES  clocks between driving the ALU inputs and sampling its
//                  outputs; 0 is treated as 1
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   command handshake
//   in_a, in_b, in_op   operands and op (00 A+B, 01 A-B, 10 |A-B|,
//                       11 (A+B) arithmetic shift right by 1)
//   in_acc              use the accumulator instead of in_a as A
//   alu_a/alu_b/alu_op  registered operands to the ALU
//   alu_result/alu_zero/alu_overflow   ALU outputs
//   out_valid/out_ready result handshake
//   out_result/out_zero/out_overflow/out_op   captured result and flags
//   busy                high while a command is settling or waiting to drain
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic [1:0]       out_op,
    output logic             busy
);

    // A zero settle time would mean sampling on the same edge the operands
    // are launched, so it is clamped to one clock.
    localparam int EFF_SETTLE = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W      = (EFF_SETTLE > 1) ? $clog2(EFF_SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EFF_SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_aluA;
    logic [WIDTH-1:0]   r_aluB;
    logic [1:0]         r_aluOp;
    logic               r_outValid;
    logic [WIDTH-1:0]   r_outResult;
    logic               r_outZero;
    logic               r_outOverflow;
    logic [1:0]         r_outOp;

    logic               w_inReady;
    logic               w_accept;
    logic [WIDTH-1:0]   w_loadA;

    // In OUT the sequencer can take a new command only on the same edge the
    // current result drains, so readiness follows the consumer directly.
    always_comb begin
        w_inReady = 1'b0;
        case (r_state)
            IDLE:    w_inReady = 1'b1;
            OUT:     w_inReady = out_ready;
            default: w_inReady = 1'b0;
        endcase
    end

    assign w_accept = in_valid && w_inReady;

    // In OUT the accumulator already holds the result being consumed, so a
    // chained command on the drain edge picks up that value.
    assign w_loadA = in_acc ? r_acc : in_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_acc         <= '0;
            r_aluA        <= '0;
            r_aluB        <= '0;
            r_aluOp       <= '0;
            r_outValid    <= 1'b0;
            r_outResult   <= '0;
            r_outZero     <= 1'b0;
            r_outOverflow <= 1'b0;
            r_outOp       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_aluA  <= w_loadA;
                        r_aluB  <= in_b;
                        r_aluOp <= in_op;
                        r_count <= CNT_LOAD;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_count != '0) begin
                        r_count <= r_count - CNT_W'(1);
                    end else begin
                        r_outResult   <= alu_result;
                        r_outZero     <= alu_zero;
                        r_outOverflow <= alu_overflow;
                        r_outOp       <= r_aluOp;
                        r_acc         <= alu_result;
                        r_outValid    <= 1'b1;
                        r_state       <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        if (w_accept) begin
                            r_aluA  <= w_loadA;
                            r_aluB  <= in_b;
                            r_aluOp <= in_op;
                            r_count <= CNT_LOAD;
                            r_state <= SETTLE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = w_inReady;
    assign alu_a        = r_aluA;
    assign alu_b        = r_aluB;
    assign alu_op       = r_aluOp;
    assign out_valid    = r_outValid;
    assign out_result   = r_outResult;
    assign out_zero     = r_outZero;
    assign out_overflow = r_outOverflow;
    assign out_op       = r_outOp;
    assign busy         = (r_state != IDLE);

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Upstream control stage for the 4-bit gate-level ALU.
- Accepts operation commands over a valid/ready handshake and drives the ALU's A, B and op inputs from registers, holding them stable.
- Waits a programmable number of clocks so the ALU's gate-delay paths can settle, then captures result/zero/overflow into an output buffer with its own valid/ready handshake.
- Keeps an accumulator of the last captured result so commands can chain on it.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- SETTLE_CYCLES, 3, clocks between driving the ALU inputs and sampling its outputs; a value of 0 is treated as 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  command valid
- in_ready  output  1  command accepted when in_valid && in_ready at a clk edge
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  2  00 A+B, 01 A-B, 10 |A-B|, 11 (A+B) arithmetic shift right by 1
- in_acc  input  1  1: use the accumulator instead of in_a as A
- alu_a  output  WIDTH  registered A to the ALU
- alu_b  output  WIDTH  registered B to the ALU
- alu_op  output  2  registered op to the ALU
- alu_result  input  WIDTH  from the ALU
- alu_zero  input  1  from the ALU
- alu_overflow  input  1  from the ALU
- out_valid  output  1  captured result valid
- out_ready  input  1  consumer ready
- out_result  output  WIDTH  captured result
- out_zero  output  1  captured zero flag
- out_overflow  output  1  captured overflow flag
- out_op  output  2  op that produced the result
- busy  output  1  high in SETTLE or OUT

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; counter = 0; accumulator = 0.
  - alu_a, alu_b, alu_op = 0; out_result, out_zero, out_overflow, out_op = 0.
  - out_valid = 0; busy = 0; in_ready = 1.
- States: IDLE, SETTLE, OUT.
- IDLE:
  - in_ready = 1.
  - On accept: alu_a <= (in_acc ? accumulator : in_a); alu_b <= in_b; alu_op <= in_op; counter <= SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - in_ready = 0; alu_* held.
  - If counter != 0: decrement.
  - If counter == 0: out_result <= alu_result; out_zero <= alu_zero; out_overflow <= alu_overflow; out_op <= alu_op; accumulator <= alu_result; out_valid <= 1; go to OUT.
- OUT:
  - out_* and alu_* held; in_ready = out_ready (combinational).
  - out_valid && out_ready with no new accept: out_valid <= 0; go to IDLE.
  - out_valid && out_ready with a simultaneous accept: out_valid <= 0; load alu_* and counter as in IDLE; go to SETTLE. The chained accumulator value is the result just consumed.
  - out_ready low: everything holds indefinitely, and no command is accepted.
- Latency: accept at edge k → alu_* valid after edge k → sample at edge k+SETTLE_CYCLES → out_valid high after that edge.
  - Back-to-back throughput is one result per SETTLE_CYCLES+1 clocks.
- alu_* change only on an accept edge or reset. They never change during SETTLE or OUT.
- The accumulator updates only on capture. in_acc=1 with no prior capture uses 0.
- Values wrap modulo 2^WIDTH. Flags are passed through from the ALU unmodified; the sequencer adds no arithmetic.
- Reset mid-SETTLE or mid-OUT:
  - The in-flight command is discarded and out_valid drops immediately.
  - No capture occurs, even if the reset deasserts on the sample edge.
- in_valid while not ready: the command is ignored, not queued. The producer must hold it.
- busy = (state != IDLE).

Test Plan:
- Reset, then in_a=3, in_b=5, in_op=00, SETTLE_CYCLES=3, out_ready=1 → alu_a=3, alu_b=5, alu_op=00 one edge after accept; out_valid exactly 3 edges later with out_result=8, out_overflow=1, out_zero=0.
- in_a=5, in_b=5, in_op=01 → out_result=0, out_zero=1, out_overflow=0.
- in_a=2, in_b=7, in_op=10 → out_result=5. Then in_acc=1, in_b=1, in_op=00 → alu_a=5, out_result=6.
- out_ready=0 for 10 cycles after out_valid, with in_valid held high → in_ready=0, out_result and alu_* stable, no second accept. Raise out_ready → second command accepted on the same edge that out_valid is consumed.
- Assert rst_n low one cycle before the sample edge → out_valid stays 0, all outputs 0, in_ready=1. Next command runs normally with accumulator 0.
- SETTLE_CYCLES=0 with in_a=4, in_b=4, in_op=11 → captured 1 edge after accept, out_result=4.
